// File: rtl/eim_txn_ctrl_if.sv
// EIM pad-side and core-side signal bundle for the EIM transaction controller.
// The controller takes the slave view; the CPU/pad model and the core take the master view.
interface eim_txn_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              eim_cs0_n;
  logic              eim_lba_n;
  logic              eim_wr_n;
  logic              eim_oe_n;
  logic [7:0]        da_in;
  logic [7:0]        da_out;
  logic              da_oe_n;
  logic              eim_wait_n;
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [7:0]        core_wdata;
  logic [7:0]        core_rdata;
  logic              core_ready;
  logic              err_pulse;

  modport slave (
    input  eim_cs0_n, eim_lba_n, eim_wr_n, eim_oe_n, da_in, core_rdata, core_ready,
    output da_out, da_oe_n, eim_wait_n, core_req, core_we, core_addr, core_wdata, err_pulse
  );

  modport master (
    output eim_cs0_n, eim_lba_n, eim_wr_n, eim_oe_n, da_in, core_rdata, core_ready,
    input  da_out, da_oe_n, eim_wait_n, core_req, core_we, core_addr, core_wdata, err_pulse
  );
endinterface

// File: rtl/eim_txn_ctrl.sv
// EIM slave transaction controller: synchronises the async EIM bus, decodes address and
// read/write phases, and issues single-outstanding requests to the register/memory core.
module eim_txn_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT     = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  eim_txn_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, ADDR, DIR, RD_REQ, RD_DRIVE, WR_DATA, WR_REQ
  } state_t;

  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] cs_sync, lba_sync, wr_sync, oe_sync;
  logic [7:0]             da_sync [SYNC_STAGES];
  logic                   lba_q, wr_q, oe_q;
  logic                   cs_s, lba_s, wr_s, oe_s;
  logic [7:0]             da_s;
  logic                   lba_fall, lba_rise, wr_fall, wr_rise, oe_fall;

  logic [CNT_W-1:0]  cnt;
  logic              core_req_q, core_we_q, err_q;
  logic [ADDR_W-1:0] core_addr_q;
  logic [7:0]        core_wdata_q, da_out_q;

  logic req_next, err_next, enter_req, ld_addr, ld_wdata, ld_rdata, ld_ff;
  logic timeout, req_done;

  // Controls idle high and data idles low so reset never fabricates a bus edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_sync  <= '1;
      lba_sync <= '1;
      wr_sync  <= '1;
      oe_sync  <= '1;
      for (int i = 0; i < SYNC_STAGES; i++) da_sync[i] <= '0;
      lba_q <= 1'b1;
      wr_q  <= 1'b1;
      oe_q  <= 1'b1;
    end else begin
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0],  bus.eim_cs0_n};
      lba_sync <= {lba_sync[SYNC_STAGES-2:0], bus.eim_lba_n};
      wr_sync  <= {wr_sync[SYNC_STAGES-2:0],  bus.eim_wr_n};
      oe_sync  <= {oe_sync[SYNC_STAGES-2:0],  bus.eim_oe_n};
      da_sync[0] <= bus.da_in;
      for (int i = 1; i < SYNC_STAGES; i++) da_sync[i] <= da_sync[i-1];
      lba_q <= lba_s;
      wr_q  <= wr_s;
      oe_q  <= oe_s;
    end
  end

  assign cs_s  = cs_sync[SYNC_STAGES-1];
  assign lba_s = lba_sync[SYNC_STAGES-1];
  assign wr_s  = wr_sync[SYNC_STAGES-1];
  assign oe_s  = oe_sync[SYNC_STAGES-1];
  assign da_s  = da_sync[SYNC_STAGES-1];

  assign lba_fall = lba_q & ~lba_s;
  assign lba_rise = ~lba_q & lba_s;
  assign wr_fall  = wr_q & ~wr_s;
  assign wr_rise  = ~wr_q & wr_s;
  assign oe_fall  = oe_q & ~oe_s;

  // A ready arriving on the last allowed cycle wins over the timeout.
  assign timeout  = core_req_q && (cnt == CNT_LAST) && !bus.core_ready;
  assign req_done = core_req_q && (bus.core_ready || timeout);

  always_comb begin
    state_next = state;
    req_next   = 1'b0;
    err_next   = 1'b0;
    enter_req  = 1'b0;
    ld_addr    = 1'b0;
    ld_wdata   = 1'b0;
    ld_rdata   = 1'b0;
    ld_ff      = 1'b0;
    case (state)
      IDLE: begin
        if (!cs_s && lba_fall) begin
          ld_addr    = 1'b1;
          state_next = ADDR;
        end
      end
      ADDR: begin
        if (cs_s)          state_next = IDLE;
        else if (lba_rise) state_next = DIR;
      end
      DIR: begin
        if (cs_s) begin
          state_next = IDLE;
        end else if (oe_fall && wr_fall) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end else if (oe_fall) begin
          enter_req  = 1'b1;
          state_next = RD_REQ;
        end else if (wr_fall) begin
          state_next = WR_DATA;
        end
      end
      WR_DATA: begin
        if (cs_s) begin
          state_next = IDLE;
        end else if (wr_rise) begin
          ld_wdata   = 1'b1;
          enter_req  = 1'b1;
          state_next = WR_REQ;
        end
      end
      // Once the core has been asked, the handshake always completes even if cs drops.
      RD_REQ: begin
        if (req_done) begin
          ld_rdata   = bus.core_ready;
          ld_ff      = !bus.core_ready;
          err_next   = !bus.core_ready;
          state_next = cs_s ? IDLE : RD_DRIVE;
        end else begin
          req_next = 1'b1;
        end
      end
      RD_DRIVE: begin
        if (cs_s || oe_s) state_next = IDLE;
      end
      WR_REQ: begin
        if (req_done) begin
          err_next   = !bus.core_ready;
          state_next = IDLE;
        end else begin
          req_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      core_req_q   <= 1'b0;
      core_we_q    <= 1'b0;
      core_addr_q  <= '0;
      core_wdata_q <= '0;
      da_out_q     <= '0;
      err_q        <= 1'b0;
      cnt          <= '0;
    end else begin
      state      <= state_next;
      core_req_q <= req_next;
      err_q      <= err_next;
      if (ld_addr)  core_addr_q  <= da_s[ADDR_W-1:0];
      if (ld_wdata) core_wdata_q <= da_s;
      if (ld_rdata)   da_out_q <= bus.core_rdata;
      else if (ld_ff) da_out_q <= 8'hFF;
      if (enter_req) begin
        cnt       <= '0;
        core_we_q <= (state == WR_DATA);
      end else if (core_req_q) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Pad drive is gated by the live synced oe/cs so it can never outlast either strobe.
  assign bus.da_oe_n    = !((state == RD_DRIVE) && !oe_s && !cs_s);
  assign bus.eim_wait_n = !((state == RD_REQ) || (state == WR_REQ));
  assign bus.da_out     = da_out_q;
  assign bus.core_req   = core_req_q;
  assign bus.core_we    = core_we_q;
  assign bus.core_addr  = core_addr_q;
  assign bus.core_wdata = core_wdata_q;
  assign bus.err_pulse  = err_q;

endmodule

// File: tb/tb_eim_txn_ctrl.sv
// Directed bench for eim_txn_ctrl: reset, write, read, timeout, cs abort, dual-strobe error,
// stray core_ready and reset in the middle of a read.
module tb_eim_txn_ctrl;
  localparam int TIMEOUT = 64;
  localparam int HOLD    = 5;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   req_rises = 0;
  int   err_count = 0;
  logic req_prev  = 1'b0;

  eim_txn_ctrl_if #(.ADDR_W(8)) bus ();

  eim_txn_ctrl #(.SYNC_STAGES(2), .ADDR_W(8), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts core_req rising edges and err_pulse cycles away from the active edge.
  always @(negedge clk) begin
    if (bus.core_req === 1'b1 && !req_prev) req_rises++;
    req_prev = (bus.core_req === 1'b1);
    if (bus.err_pulse === 1'b1) err_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic applyStimulus(input logic cs, input logic lba, input logic wr, input logic oe,
                               input logic [7:0] da, input int hold);
    bus.eim_cs0_n = cs;
    bus.eim_lba_n = lba;
    bus.eim_wr_n  = wr;
    bus.eim_oe_n  = oe;
    bus.da_in     = da;
    for (int i = 0; i < hold; i++) tick();
  endtask

  task automatic waitReq(input string tag);
    int n = 0;
    while (bus.core_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(bus.core_req), 32'd1);
  endtask

  // Address phase followed by lba release, leaving the FSM in the direction phase.
  task automatic addrPhase(input logic [7:0] addr);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, addr, HOLD);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, addr, HOLD);
  endtask

  initial begin
    int n;
    int rises0, errs0;
    rst_n           = 1'b0;
    bus.eim_cs0_n   = 1'b1;
    bus.eim_lba_n   = 1'b1;
    bus.eim_wr_n    = 1'b1;
    bus.eim_oe_n    = 1'b1;
    bus.da_in       = 8'h00;
    bus.core_rdata  = 8'h00;
    bus.core_ready  = 1'b0;

    // Reset held with the strobes toggling underneath it.
    for (int i = 0; i < 3; i++) begin
      bus.eim_cs0_n = 1'b0;
      bus.eim_lba_n = i[0];
      bus.eim_oe_n  = ~i[0];
      bus.eim_wr_n  = i[0];
      tick();
      checkOutput("rst_da_oe_n", 32'(bus.da_oe_n), 32'd1);
      checkOutput("rst_wait_n", 32'(bus.eim_wait_n), 32'd1);
      checkOutput("rst_core_req", 32'(bus.core_req), 32'd0);
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 0);
    rst_n = 1'b1;
    for (int i = 0; i < HOLD; i++) tick();
    checkOutput("rel_da_out", 32'(bus.da_out), 32'h00);
    checkOutput("rel_da_oe_n", 32'(bus.da_oe_n), 32'd1);
    checkOutput("rel_wait_n", 32'(bus.eim_wait_n), 32'd1);
    checkOutput("rel_core_req", 32'(bus.core_req), 32'd0);
    checkOutput("rel_core_we", 32'(bus.core_we), 32'd0);
    checkOutput("rel_core_addr", 32'(bus.core_addr), 32'h00);
    checkOutput("rel_core_wdata", 32'(bus.core_wdata), 32'h00);
    checkOutput("rel_err", 32'(bus.err_pulse), 32'd0);

    // Write 0xA5 to address 0x05, core ready after 3 cycles.
    addrPhase(8'h05);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, HOLD);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'hA5, 0);
    waitReq("wr_req_seen");
    checkOutput("wr_we", 32'(bus.core_we), 32'd1);
    checkOutput("wr_addr", 32'(bus.core_addr), 32'h05);
    checkOutput("wr_wdata", 32'(bus.core_wdata), 32'hA5);
    checkOutput("wr_wait_n", 32'(bus.eim_wait_n), 32'd0);
    tick();
    tick();
    checkOutput("wr_req_held", 32'(bus.core_req), 32'd1);
    bus.core_ready = 1'b1;
    tick();
    bus.core_ready = 1'b0;
    checkOutput("wr_req_drop", 32'(bus.core_req), 32'd0);
    checkOutput("wr_wait_rel", 32'(bus.eim_wait_n), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, HOLD);
    checkOutput("wr_one_req", 32'(req_rises), 32'd1);
    checkOutput("wr_no_err", 32'(err_count), 32'd0);

    // Read address 0x03, core returns 0x5C after 4 cycles.
    addrPhase(8'h03);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 0);
    waitReq("rd_req_seen");
    checkOutput("rd_we", 32'(bus.core_we), 32'd0);
    checkOutput("rd_addr", 32'(bus.core_addr), 32'h03);
    bus.core_rdata = 8'h5C;
    for (int i = 0; i < 3; i++) begin
      checkOutput("rd_wait_low", 32'(bus.eim_wait_n), 32'd0);
      tick();
    end
    bus.core_ready = 1'b1;
    tick();
    bus.core_ready = 1'b0;
    checkOutput("rd_req_drop", 32'(bus.core_req), 32'd0);
    checkOutput("rd_wait_rel", 32'(bus.eim_wait_n), 32'd1);
    checkOutput("rd_da_out", 32'(bus.da_out), 32'h5C);
    checkOutput("rd_drive", 32'(bus.da_oe_n), 32'd0);
    bus.eim_oe_n = 1'b1;
    tick();
    checkOutput("rd_drive_hold", 32'(bus.da_oe_n), 32'd0);
    tick();
    tick();
    checkOutput("rd_release", 32'(bus.da_oe_n), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, HOLD);
    checkOutput("rd_no_err", 32'(err_count), 32'd0);

    // Read with no core_ready: abandoned after TIMEOUT request cycles.
    addrPhase(8'h07);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 0);
    waitReq("to_req_seen");
    n = 0;
    while (bus.core_req === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checkOutput("to_req_cycles", 32'(n), 32'(TIMEOUT));
    checkOutput("to_err_pulse", 32'(bus.err_pulse), 32'd1);
    checkOutput("to_da_ff", 32'(bus.da_out), 32'hFF);
    checkOutput("to_drive", 32'(bus.da_oe_n), 32'd0);
    tick();
    checkOutput("to_err_once", 32'(bus.err_pulse), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, HOLD);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, HOLD);
    checkOutput("to_err_count", 32'(err_count), 32'd1);

    // cs released in the direction phase: silent abort.
    rises0 = req_rises;
    errs0  = err_count;
    addrPhase(8'h22);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 10);
    checkOutput("abort_no_req", 32'(req_rises - rises0), 32'd0);
    checkOutput("abort_no_err", 32'(err_count - errs0), 32'd0);
    checkOutput("abort_wait_n", 32'(bus.eim_wait_n), 32'd1);
    checkOutput("abort_da_oe_n", 32'(bus.da_oe_n), 32'd1);

    // oe and wr falling together: protocol error, no core access.
    addrPhase(8'h33);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 10);
    checkOutput("dual_err", 32'(err_count - errs0), 32'd1);
    checkOutput("dual_no_req", 32'(req_rises - rises0), 32'd0);
    checkOutput("dual_da_oe_n", 32'(bus.da_oe_n), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, HOLD);

    // Stray core_ready in IDLE must not load da_out or start anything.
    bus.core_rdata = 8'h99;
    bus.core_ready = 1'b1;
    tick();
    bus.core_ready = 1'b0;
    tick();
    checkOutput("stray_da_out", 32'(bus.da_out), 32'hFF);
    checkOutput("stray_no_req", 32'(req_rises - rises0), 32'd0);
    checkOutput("stray_wait_n", 32'(bus.eim_wait_n), 32'd1);

    // A normal write still works afterwards, ready on the first request cycle.
    addrPhase(8'h10);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h3C, HOLD);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'h3C, 0);
    waitReq("wr2_req_seen");
    checkOutput("wr2_addr", 32'(bus.core_addr), 32'h10);
    checkOutput("wr2_wdata", 32'(bus.core_wdata), 32'h3C);
    checkOutput("wr2_we", 32'(bus.core_we), 32'd1);
    bus.core_ready = 1'b1;
    tick();
    bus.core_ready = 1'b0;
    checkOutput("wr2_req_drop", 32'(bus.core_req), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, HOLD);

    // Reset while a read request is outstanding.
    addrPhase(8'h44);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 0);
    waitReq("mid_req_seen");
    rst_n = 1'b0;
    tick();
    checkOutput("mid_core_req", 32'(bus.core_req), 32'd0);
    checkOutput("mid_wait_n", 32'(bus.eim_wait_n), 32'd1);
    checkOutput("mid_da_oe_n", 32'(bus.da_oe_n), 32'd1);
    checkOutput("mid_core_addr", 32'(bus.core_addr), 32'h00);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, HOLD);
    checkOutput("mid_idle_req", 32'(bus.core_req), 32'd0);
    checkOutput("mid_idle_oe", 32'(bus.da_oe_n), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] simulation watchdog expired");
  end

endmodule

// File: doc/eim_txn_ctrl.md
Name: eim_txn_ctrl

Overview:
- FPGA-side EIM slave transaction controller. Sits between the EIM pad cells (BBPD bidirectional buffers) and the on-chip register/memory core.
- Synchronises asynchronous EIM control and data signals into the clock domain and decodes address/read/write phases.
- Presents a single-outstanding req/ready handshake to the core and drives the data-bus tristate enable and eim_wait_n.

Parameters:
- SYNC_STAGES, 2, synchroniser depth for every EIM input (minimum 2).
- ADDR_W, 8, core address width; address latched from da_in[ADDR_W-1:0]. Must be ≤ 8.
- TIMEOUT, 64, clk cycles allowed for core_ready before the core request is abandoned.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- eim_cs0_n  in  1  chip select, async, active low.
- eim_lba_n  in  1  address latch, async, active low.
- eim_wr_n  in  1  write strobe, async, active low.
- eim_oe_n  in  1  output enable, async, active low.
- da_in  in  8  pad O data from the bidirectional cells, async.
- da_out  out  8  pad I data.
- da_oe_n  out  1  pad T: 1 = high-Z, 0 = drive.
- eim_wait_n  out  1  wait to CPU, active low.
- core_req  out  1  core access request.
- core_we  out  1  1 = write, 0 = read; valid with core_req.
- core_addr  out  ADDR_W  access address.
- core_wdata  out  8  write data.
- core_rdata  in  8  read data; valid when core_ready=1.
- core_ready  in  1  core completion, single-cycle.
- err_pulse  out  1  one-cycle pulse on protocol error or timeout.

Behaviour:
- Synchronisation and edge detection:
  - All EIM inputs pass through SYNC_STAGES flops.
  - Edges are detected on synchronised values against one extra registered copy.
  - Logic uses only synchronised signals. Input-to-decision latency is SYNC_STAGES+1 cycles.
- Reset (rst_n=0 at a clk edge): state=IDLE, da_out=0, da_oe_n=1, eim_wait_n=1, core_req=0, core_we=0, core_addr=0, core_wdata=0, err_pulse=0, timeout counter=0. Sync flops reset to 1 (inactive) for control signals and 0 for data.
- Reset mid-transaction: immediate return to IDLE with the bus released. Nothing is issued to the core.
- FSM states:
  - IDLE: on cs low and lba falling edge, core_addr ← sync da[ADDR_W-1:0]; go ADDR.
  - ADDR: on lba rising edge, go DIR.
  - DIR:
    - oe falling only → RD_REQ.
    - wr falling only → WR_DATA.
    - Both in the same cycle → err_pulse, go IDLE.
  - RD_REQ:
    - core_req=1, core_we=0, eim_wait_n=0.
    - On core_ready: da_out ← core_rdata, go RD_DRIVE.
    - On timeout: da_out ← 8'hFF, err_pulse, go RD_DRIVE.
  - RD_DRIVE: da_oe_n=0, eim_wait_n=1. On oe rising edge, da_oe_n=1 next cycle, go IDLE.
  - WR_DATA: on wr rising edge, core_wdata ← sync da; go WR_REQ.
  - WR_REQ:
    - core_req=1, core_we=1, eim_wait_n=0.
    - On core_ready or timeout (timeout also pulses err_pulse), go IDLE.
- core_req protocol:
  - Rises on the cycle after entering RD_REQ/WR_REQ.
  - core_addr, core_we and core_wdata are stable while core_req=1.
  - core_req drops the cycle after core_ready is sampled.
  - core_ready while core_req=0 is ignored.
- Timeout counter: clears on entry to RD_REQ/WR_REQ and increments each cycle core_req=1. Reaching TIMEOUT-1 with no core_ready is a timeout.
- Chip-select deassertion:
  - Synced cs high in ADDR, DIR, WR_DATA or RD_DRIVE: abort to IDLE, da_oe_n=1 next cycle, no core access, no err_pulse.
  - Synced cs high during RD_REQ/WR_REQ: the core handshake completes, then the FSM returns to IDLE with no bus drive.
- Back-to-back transactions: an lba falling edge on the same cycle IDLE is re-entered is missed. The CPU must insert at least SYNC_STAGES+2 clk of idle between transactions.
- da_oe_n is never 0 unless synced oe=0 and cs=0.

Test Plan:
- Reset: hold rst_n=0 for 3 clk with lba/oe/wr toggling → da_oe_n=1, eim_wait_n=1, core_req=0 throughout; all outputs at reset values after release.
- Write: cs=0, lba low with da=8'h05, lba high, wr low with da=8'hA5, wr high → one core_req with we=1, addr=5, wdata=A5; core_ready after 3 cycles → core_req low next cycle, state IDLE.
- Read: address 8'h03, oe low, core_rdata=8'h5C with ready after 4 cycles → eim_wait_n low until ready; da_out=5C, da_oe_n=0 until synced oe rises; da_oe_n=1 the cycle after.
- Timeout: read with core_ready never asserted → err_pulse exactly once at TIMEOUT cycles, da_out=FF driven while oe low.
- Abort: cs rises in DIR before oe/wr → no core_req, no err_pulse, IDLE. Simultaneous oe and wr falling in DIR → err_pulse, no core_req.
- Stray core_ready: pulse core_ready while in IDLE → no state change, no capture into da_out.
